mulsum_seq: RTL
===============

# mulsum_seq

Sequential shift-and-add multiply-accumulate unit computing P = Q·M + R, the inverse of the team's non-restoring divider. It rebuilds a dividend from a quotient, divisor and remainder, and is used in the RSA datapath for two jobs: checking divider results and forming products ahead of modular reduction. It uses the same start/done handshake as the divider, so the two blocks can be chained by the same controller.

## Interface
Parameters:
- WIDTH, 1025: operand width in bits; matches the divider's [1024:0] buses.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Q  input  WIDTH  multiplier (quotient).
- M  input  WIDTH  multiplicand (divisor).
- R  input  WIDTH  addend (remainder).
- P  output  2·WIDTH  result Q·M+R; registered.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; P is valid when it is high.
- err  output  1  range flag (see Configuration); registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 at a clock edge:
  - Latch Q, M and R.
  - Load the accumulator with R zero-extended to 2·WIDTH.
  - Set count=0, clear err and enter RUN.
- IDLE with start=0: P holds its last value.
- RUN, one multiplier bit per cycle, LSB first:
  - If Q[count]=1, then acc ← acc + (M << count); otherwise acc is unchanged.
  - count increments each cycle.
  - After exactly WIDTH RUN cycles, go to DONE.
- DONE, for one cycle:
  - P ← acc and done=1.
  - Next edge returns to IDLE.
- Arithmetic:
  - The largest possible result, (2^W−1)² + (2^W−1) = 2^2W − 2^W, fits in 2·WIDTH bits, so no overflow is possible and no carry-out exists.
  - Operands are unsigned.
- start while busy: ignored. No queuing, and latched operands do not change.
- Input operands may change freely after the start edge.
- Q=0 or M=0: still takes the full WIDTH cycles; P=R.
- The implementation may use a right-shifting accumulator instead of the left-shifted M, as long as the result and cycle counts are identical.

## Timing
- Reset values: P=0, busy=0, done=0, err=0, state=IDLE, count=0.
- Reset asserted mid-operation: the above values apply immediately, regardless of clock. Operation is aborted and no done is issued.
- Latency, with start sampled at edge t:
  - busy=1 from after edge t.
  - RUN covers edges t+1 … t+W.
  - P updates and done=1 after edge t+W+1.
  - busy=0 and done=0 after edge t+W+2.
- Throughput: one operation per W+2 cycles. A start held high continuously is accepted again at the first IDLE edge, i.e. edge t+W+2.
- done is never high for more than one cycle.
- P stays stable from done until the next DONE state.

## Configuration
- MULSUM_RANGE_CHECK_EN defined:
  - In the start cycle, compare the latched R against the latched M.
  - If R ≥ M, or M=0, set err=1 in the start cycle. err holds until the next accepted start or reset.
  - The result is still computed normally.
- Not defined: err is tied to 0. No comparator logic is built; all other behaviour is identical.

## Test plan
- WIDTH=8, Q=13, M=7, R=5, start pulsed at edge 0 → done high exactly after edge 9, P=96, err=0, busy low after edge 10.
- WIDTH=8, Q=255, M=255, R=254 → P=65279. Repeat with R=255 → P=65280, no overflow; err=1 only when the macro is defined.
- WIDTH=8, Q=0, M=200, R=17 → P=17 after the full 9-cycle latency. Then M=0, R=3 → P=3, with err=1 when the macro is defined.
- WIDTH=8, busy mid-RUN: pulse start with new operands Q=1, M=1, R=0 → ignored, original P delivered. Hold start high → second operation begins at edge 10 and its done follows after edge 19.
- Any WIDTH: assert rst at RUN cycle 4 → P=0, busy=0, done=0 immediately and no done pulse. After release, a new start completes correctly.
- WIDTH=1025, random 1025-bit Q and M, with R < M from a divider run → P equals the original dividend, done after 1026 cycles.

Source files
------------

// File: rtl/mulsum_seq.sv
// Sequential shift-and-add multiply-accumulate: P = Q*M + R, one multiplier bit per cycle.
// Optional range flag (R >= M or M == 0) is built only when MULSUM_RANGE_CHECK_EN is defined.
module mulsum_seq #(
    parameter int WIDTH = 1025
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     R,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   msh_q, msh_d;
    logic [WIDTH-1:0]     qsh_q, qsh_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef MULSUM_RANGE_CHECK_EN
    logic                 err_q, err_d;

    function automatic logic range_err(input logic [WIDTH-1:0] r_v, input logic [WIDTH-1:0] m_v);
        return (r_v >= m_v) || (m_v == {WIDTH{1'b0}});
    endfunction
`endif

    // Next-state and datapath: M is shifted left and Q right so only bit 0 of Q is ever inspected.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        msh_d   = msh_q;
        qsh_d   = qsh_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULSUM_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    qsh_d   = Q;
                    msh_d   = {{WIDTH{1'b0}}, M};
                    acc_d   = {{WIDTH{1'b0}}, R};
                    count_d = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef MULSUM_RANGE_CHECK_EN
                    err_d   = range_err(R, M);
`endif
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (qsh_q[0]) begin
                    acc_d = acc_q + msh_q;
                end else begin
                    acc_d = acc_q;
                end
                qsh_d   = qsh_q >> 1;
                msh_d   = msh_q << 1;
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // busy stays registered high through the cycle done is visible
                p_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= {CW{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            msh_q   <= {(2*WIDTH){1'b0}};
            qsh_q   <= {WIDTH{1'b0}};
            p_q     <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULSUM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            msh_q   <= msh_d;
            qsh_q   <= qsh_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULSUM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef MULSUM_RANGE_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule
